// File: rtl/fir4_pkg.sv
// ============================================================================
// Module      : fir4_pkg
// Description : Shared types, widths and helpers for the 4-tap FIR inverter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir4_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam int DEF_W = 16;
    localparam int DW    = DEF_W + 4;

    // Moving-sum width: four w-bit terms need two extra bits.
    function automatic int sum_w(input int w);
        return w + 2;
    endfunction

    // Datapath width: sum width plus sign and headroom for the h3 add.
    function automatic int dp_w(input int w);
        return w + 4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir4inv_hist.sv
// ============================================================================
// Module      : fir4inv_hist
// Description : 4-deep shift register of recovered samples, exposing the oldest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir4inv_hist #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [W-1:0] h_oldest
);

    logic [W-1:0] hist_q [4];
    logic [W-1:0] hist_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hist_d[i] = hist_q[i];
        end
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                hist_d[i] = '0;
            end
        end else if (shift) begin
            hist_d[0] = din;
            for (int i = 1; i < 4; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign h_oldest = hist_q[3];

endmodule

`default_nettype wire

// File: rtl/fir4_inverse.sv
// ============================================================================
// Module      : fir4_inverse
// Description : Recovers w-bit samples from a 4-tap moving sum, flags faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir4_inverse
    import fir4_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [W+1:0]        s_in,
    input  logic                resync,
    output logic                out_valid,
    output logic [W-1:0]        a_out,
    output logic                err,
    output logic [CW-1:0]       err_count
);

    localparam int            c_SW  = sum_w(W);
    localparam int            c_DW  = dp_w(W);
    localparam logic [CW-1:0] c_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [c_SW-1:0]   s_prev_q, s_prev_d;
    logic [W-1:0]      a_out_q, a_out_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic [CW-1:0]     err_count_q, err_count_d;

    logic [W-1:0]      w_h3;
    logic [c_DW-1:0]   w_diff;
    logic              w_legal;
    logic              w_shift;

    // Two's-complement wrap in c_DW bits yields the signed result directly.
    assign w_diff  = {2'b00, s_in} - {2'b00, s_prev_q} + {4'b0000, w_h3};
    assign w_legal = (w_diff[c_DW-1:W] == '0);

    always_comb begin
        state_d     = state_q;
        s_prev_d    = s_prev_q;
        a_out_d     = a_out_q;
        out_valid_d = 1'b0;
        err_d       = err_q;
        err_count_d = err_count_q;
        w_shift     = 1'b0;

        if (resync) begin
            state_d  = RUN;
            s_prev_d = '0;
            err_d    = 1'b0;
        end else if (state_q == RUN && in_valid) begin
            if (w_legal) begin
                s_prev_d    = s_in;
                a_out_d     = w_diff[W-1:0];
                out_valid_d = 1'b1;
                w_shift     = 1'b1;
            end else begin
                state_d = FAULT;
                err_d   = 1'b1;
                if (err_count_q != {CW{1'b1}}) begin
                    err_count_d = err_count_q + c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            s_prev_q    <= '0;
            a_out_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            s_prev_q    <= s_prev_d;
            a_out_q     <= a_out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    fir4inv_hist #(
        .W (W)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .clr      (resync),
        .shift    (w_shift),
        .din      (w_diff[W-1:0]),
        .h_oldest (w_h3)
    );

    assign out_valid = out_valid_q;
    assign a_out     = a_out_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fir4_inverse.sv
// ============================================================================
// Module      : tb_fir4_inverse
// Description : Scoreboard bench for fir4_inverse with a moving-sum reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir4_inverse;

    localparam int W    = 16;
    localparam int CW   = 8;
    localparam int AMAX = 65535;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W+1:0]  s_in;
    logic          resync;
    logic          out_valid;
    logic [W-1:0]  a_out;
    logic          err;
    logic [CW-1:0] err_count;

    fir4_inverse #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .s_in      (s_in),
        .resync    (resync),
        .out_valid (out_valid),
        .a_out     (a_out),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    // Reference: last three recovered samples, newest first.
    int m_hist[3];
    bit m_fault;
    int m_cnt;
    int m_aout;
    bit m_pulse;
    // Upstream encoder: last three raw samples it was fed.
    int e_hist[3];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // The moving sum says s[n] = a[n] + a[n-1] + a[n-2] + a[n-3].
    function automatic void model_step(input bit rst, input bit v, input int s, input bit rs);
        int d;
        m_pulse = 1'b0;
        if (rst) begin
            m_hist  = '{0, 0, 0};
            m_fault = 1'b0;
            m_cnt   = 0;
            m_aout  = 0;
        end else if (rs) begin
            m_hist  = '{0, 0, 0};
            m_fault = 1'b0;
        end else if (v && !m_fault) begin
            d = s - (m_hist[0] + m_hist[1] + m_hist[2]);
            if (d >= 0 && d <= AMAX) begin
                m_hist[2] = m_hist[1];
                m_hist[1] = m_hist[0];
                m_hist[0] = d;
                m_aout    = d;
                m_pulse   = 1'b1;
                exp_q.push_back(d);
            end else begin
                m_fault = 1'b1;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
        end
    endfunction

    function automatic int enc(input int a);
        int s;
        s = a + e_hist[0] + e_hist[1] + e_hist[2];
        e_hist[2] = e_hist[1];
        e_hist[1] = e_hist[0];
        e_hist[0] = a;
        return s;
    endfunction

    task automatic cyc(input bit v, input int s, input bit rs, input bit rst = 1'b0);
        reset    = rst;
        in_valid = v;
        s_in     = s[W+1:0];
        resync   = rs;
        @(posedge clk);
        model_step(rst, v, s, rs);
        #1;
        check("out_valid", int'(out_valid), int'(m_pulse));
        check("err", int'(err), int'(m_fault));
        check("err_count", int'(err_count), m_cnt);
        check("a_out_hold", int'(a_out), m_aout);
        reset    = 1'b0;
        in_valid = 1'b0;
        resync   = 1'b0;
    endtask

    task automatic do_reset();
        cyc(1'b0, 0, 1'b0, 1'b1);
        e_hist = '{0, 0, 0};
    endtask

    // Monitor: every presented output must match the oldest expected sample.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", a_out);
            end else begin
                check("a_out_stream", int'(a_out), exp_q.pop_front());
            end
        end
    end

    initial begin
        int t1[5]  = '{1, 3, 6, 10, 14};
        int t3[5]  = '{'h0FFFF, 'h1FFFE, 'h2FFFD, 'h3FFFC, 'h3FFFC};
        int r;

        reset = 1'b1; in_valid = 1'b0; resync = 1'b0; s_in = '0;
        m_hist = '{0, 0, 0}; e_hist = '{0, 0, 0};
        m_fault = 1'b0; m_cnt = 0; m_aout = 0; m_pulse = 1'b0;
        do_reset();
        do_reset();

        foreach (t1[i]) cyc(1'b1, t1[i], 1'b0);
        check("t1_last", int'(a_out), 5);

        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, t1[i], 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b0);
        for (int i = 3; i < 5; i++) cyc(1'b1, t1[i], 1'b0);
        check("t2_last", int'(a_out), 5);

        do_reset();
        foreach (t3[i]) cyc(1'b1, t3[i], 1'b0);
        check("t3_full_scale", int'(a_out), AMAX);

        do_reset();
        cyc(1'b1, 5, 1'b0);
        cyc(1'b1, 3, 1'b0);
        check("t4_err_count", int'(err_count), 1);
        cyc(1'b1, 9, 1'b0);
        cyc(1'b1, 9, 1'b0);

        cyc(1'b1, 9, 1'b1);
        cyc(1'b1, 7, 1'b0);
        check("t5_a_out", int'(a_out), 7);
        check("t5_err_count", int'(err_count), 1);

        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, t1[i], 1'b0);
        cyc(1'b1, 10, 1'b0, 1'b1);
        check("t6_reset_a_out", int'(a_out), 0);
        cyc(1'b1, 4, 1'b0);
        check("t6_a_out", int'(a_out), 4);
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 0, 1'b1);
            cyc(1'b1, 'h10000, 1'b0);
        end
        check("t6_saturated", int'(err_count), 255);
        cyc(1'b0, 0, 1'b1);
        cyc(1'b1, 'h3FFFF, 1'b0);

        do_reset();
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                cyc(1'b0, 0, 1'b0);
            end else if (r < 11) begin
                cyc(1'($urandom_range(0, 1)), $urandom_range(0, 'h3FFFF), 1'b1);
                e_hist = '{0, 0, 0};
            end else if (r < 14) begin
                cyc(1'b1, $urandom_range(0, 'h3FFFF), 1'b0);
            end else if (r < 15) begin
                cyc(1'b1, 'h3FFFF, 1'b0);
            end else if (r < 16) begin
                cyc(1'b1, $urandom_range(0, 'h3FFFF), 1'b0, 1'b1);
                e_hist = '{0, 0, 0};
            end else begin
                cyc(1'b1, enc($urandom_range(0, AMAX)), 1'b0);
            end
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir4_inverse.md
Name: fir4_inverse

Overview:
- Recovers the original w-bit sample stream from the (w+2)-bit output of the team's 4-tap unit-coefficient moving-sum FIR, where s[n] = a[n] + a[n-1] + a[n-2] + a[n-3].
- Sits at the receiving end of the link, downstream of the FIR.
- Uses the recursion a[n] = s[n] - s[n-1] + a[n-4], with a history of recovered samples.
- Checks stream consistency and latches a fault on any sample that is not a legal unsigned w-bit value.

Parameters:
w  16  width of recovered samples; input sum width is w+2
CW  8  width of the saturating error counter

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
in_valid  input  1  s_in carries a new FIR output sample this cycle
s_in  input  w+2  unsigned moving-sum sample
resync  input  1  pulse; zero history, equivalent to an encoder reset
out_valid  output  1  a_out valid this cycle
a_out  output  w  recovered sample
err  output  1  sticky consistency fault
err_count  output  CW  number of fault entries, saturating

Behaviour:
- Reset values: out_valid=0, a_out=0, err=0, err_count=0, FSM=RUN, all history registers=0.
- History state:
  - s_prev holds w+2 bits.
  - h0..h3 hold w bits each; h0 is the newest recovered sample.
  - Zero history matches an encoder whose pre-reset inputs were 0.
- Arithmetic, computed signed in w+4 bits: d = s_in - s_prev + h3.
  - Legal when 0 <= d <= 2^w - 1.
  - a_out takes d[w-1:0].
- Latency: one cycle. A sample accepted at edge k appears at edge k+1 with out_valid=1.
- out_valid is a single-cycle pulse per accepted sample. When in_valid=0, all state holds and out_valid=0.
- FSM RUN, on in_valid=1 and resync=0:
  - Legal d: s_prev<=s_in, h0<=d, h1<=h0, h2<=h1, h3<=h2, a_out<=d, out_valid<=1.
  - Illegal d: err<=1, err_count increments (saturating at 2^CW-1), go to FAULT, out_valid<=0, history not updated, a_out holds.
- FSM FAULT:
  - in_valid ignored; out_valid=0; err stays 1.
  - Leaves FAULT only via resync or reset.
- resync, in any state:
  - Clears s_prev and h0..h3.
  - Clears err.
  - FSM goes to RUN.
  - out_valid=0 that cycle.
  - err_count is NOT cleared.
  - resync has priority over a same-cycle in_valid; that sample is dropped.
- Reset mid-stream: takes effect on the next edge and overrides everything, including resync. No partial history survives.
- The block carries no backpressure; the upstream FIR produces one sample per valid cycle.
- Boundary rules:
  - s_in = 2^(w+2)-1 is accepted and checked arithmetically; no overflow is possible in w+4 bits.
  - An err_count at maximum stays at maximum.

Decomposition:
- Shared package fir4_pkg holds:
  - enum state_t {RUN, FAULT}
  - function sum_w(w) returning w+2
  - localparam DW = w+4 for the datapath width
- One sub-module, fir4inv_hist: a 4-deep w-bit shift register with shift enable and synchronous clear. The main module holds the FSM, datapath and counter.

Test Plan (w=16):
1. Reset, then s_in = 1,3,6,10,14 on consecutive valid cycles -> a_out = 1,2,3,4,5, each one cycle after input, out_valid high 5 cycles; err=0.
2. Same stream with in_valid low for 3 cycles between the 3rd and 4th samples -> identical a_out values; out_valid low during the gap; no state change.
3. Full-scale: s_in = 0x0FFFF, 0x1FFFE, 0x2FFFD, 0x3FFFC, 0x3FFFC -> a_out = 0xFFFF five times; err=0.
4. After reset, s_in = 5 then 3:
   - First sample -> a_out = 5.
   - Second sample (d = -2) -> err=1, err_count=1, FSM=FAULT, out_valid stays 0.
   - Further valid samples produce nothing.
5. From FAULT, assert resync together with in_valid (s_in=9), then s_in=7 next cycle:
   - The s_in=9 sample is dropped.
   - The s_in=7 sample -> a_out=7, err=0, err_count=1.
6. Drive a stream to mid-sequence, assert reset for 1 cycle, then s_in=4:
   - Outputs return to 0 after reset.
   - The s_in=4 sample -> a_out=4.
   - Force 256 faults (with resync between each) -> err_count saturates at 255.
